// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the shared external memory pins (PSRAM=req0, PCM=req1)
// with a turnaround gap on hand-over. Define ARB_WATCHDOG_EN to add the hold-time watchdog and
// its sticky timeout output.
module mem_bus_arbiter #(
    parameter int ADDR_BITS   = 24,
    parameter int TURN_CYCLES = 2,
    parameter int HOLD_MAX    = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0,
    input  logic                   req1,
    output logic                   gnt0,
    output logic                   gnt1,
    input  logic                   oe_n0,
    input  logic                   oe_n1,
    input  logic                   we_n0,
    input  logic                   we_n1,
    input  logic [ADDR_BITS-1:1]   addr0,
    input  logic [ADDR_BITS-1:1]   addr1,
    input  logic [15:0]            dout0,
    input  logic [15:0]            dout1,
    output logic [15:0]            din0,
    output logic [15:0]            din1,
    output logic                   mem_oe_n,
    output logic                   mem_we_n,
    output logic [ADDR_BITS-1:1]   mem_addr,
    inout  wire  [15:0]            mem_data,
    output logic [1:0]             owner
`ifdef ARB_WATCHDOG_EN
    ,
    output logic                   timeout
`endif
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

    // With no turnaround the owner hands straight back to IDLE for re-arbitration.
    localparam state_t REL = (TURN_CYCLES > 0) ? TURN : IDLE;

    if (TURN_CYCLES < 0 || TURN_CYCLES > 15 || HOLD_MAX < 2) begin : g_param_check
        $error("mem_bus_arbiter: TURN_CYCLES must be 0..15 and HOLD_MAX at least 2");
    end

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] turn_q, turn_d;
    logic       gnt0_q, gnt1_q;
    logic       own0, own1;
    logic       revoke;

    assign own0 = state_q == OWN0;
    assign own1 = state_q == OWN1;

`ifdef ARB_WATCHDOG_EN
    localparam int HW = $clog2(HOLD_MAX) + 1;

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q;

    // The limit only bites when the other side is actually waiting.
    assign revoke  = hold_q == HW'(HOLD_MAX - 1) && ((own0 && req1) || (own1 && req0));
    assign timeout = timeout_q;

    // Hold counter restarts on every new ownership and saturates at the limit.
    always_comb begin
        hold_d = (!(own0 || own1) || state_d != state_q) ? '0 :
                 (hold_q == HW'(HOLD_MAX - 1)) ? hold_q : hold_q + HW'(1);
    end

    // Watchdog registers; timeout is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_q | revoke;
        end
    end
`else
    assign revoke = 1'b0;
`endif

    // State, fairness bit, turnaround counter and registered grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            turn_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            turn_q  <= turn_d;
            gnt0_q  <= state_d == OWN0;
            gnt1_q  <= state_d == OWN1;
        end
    end

    // Next state: round-robin on ties, no preemption, owner release goes through the gap.
    always_comb begin
        case (state_q)
            IDLE:    state_d = (req0 && (!req1 || last_q)) ? OWN0 : req1 ? OWN1 : IDLE;
            OWN0:    state_d = (!req0 || revoke) ? REL : OWN0;
            OWN1:    state_d = (!req1 || revoke) ? REL : OWN1;
            default: state_d = (turn_q == 4'd0) ? IDLE : TURN;
        endcase
        turn_d = (state_q != TURN) ? 4'(TURN_CYCLES - 1) : turn_q - 4'd1;
        last_d = (state_d == OWN0) ? 1'b0 : (state_d == OWN1) ? 1'b1 : last_q;
    end

    // Pin mux and read-data return; only the current owner ever reaches the pins.
    always_comb begin
        mem_oe_n = own0 ? oe_n0 : own1 ? oe_n1 : 1'b1;
        mem_we_n = own0 ? we_n0 : own1 ? we_n1 : 1'b1;
        mem_addr = own0 ? addr0 : own1 ? addr1 : '0;
        din0     = (own0 && !oe_n0) ? mem_data : 16'h0;
        din1     = (own1 && !oe_n1) ? mem_data : 16'h0;
        owner    = {own1, own0};
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign mem_data = (own0 && oe_n0) ? dout0 : (own1 && oe_n1) ? dout1 : 16'hzzzz;
endmodule
